ysyx_25060170_wbu: RTL and testbench
====================================

# ysyx_25060170_wbu

Write-back and next-PC unit at the consuming end of the control-unit interface. It accepts one decoded instruction per handshake, together with the control bits (jal, branch, brlt, regS, RegW, PCx1) and EXU results. It sequences load data returns from data memory, drives the register-file write port, and owns the architectural PC and the retired-instruction counter.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IDU/EXU presents an instruction this cycle
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- jal, branch, brlt, RegW, PCx1  in  1 each  control bits from the control unit
- regS  in  2  write-back select: 0 ALU, 1 memory, 2 PC+4, 3 PC+imm
- rd  in  5  destination register index
- imm  in  32  sign-extended immediate
- alu_result  in  32  EXU result (sum for jalr and loads, difference for branches)
- alu_zero  in  1  alu_result == 0
- alu_lt  in  1  signed rs1 < rs2
- mem_req  out  1  one-cycle load request pulse
- mem_addr  out  32  load address, held stable while waiting
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- rf_wen  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  5  write index
- rf_wdata  out  32  write data
- pc  out  32  current architectural PC
- instret  out  64  retired-instruction count
- busy  out  1  high in S_MEM

## Operation
- States: S_IDLE and S_MEM. in_ready = (state == S_IDLE).
- On accept in S_IDLE with regS != 1, the instruction commits in the same cycle:
  - rf write: rf_wen = RegW && (rd != 0).
  - rf_wdata by regS: 0 → alu_result; 2 → pc+4; 3 → pc+imm.
  - Next PC priority:
    - PCx1 → alu_result & ~32'h1
    - else jal → pc+imm
    - else branch && alu_zero → pc+imm
    - else brlt && alu_lt → pc+imm
    - else pc+4
  - instret increments by 1.
- On accept with regS == 1 (load):
  - Pulse mem_req for one cycle, latch mem_addr = alu_result, rd, and RegW.
  - Go to S_MEM. PC is unchanged.
- In S_MEM, on mem_rvalid:
  - rf_wen = latched RegW && (latched rd != 0), rf_wdata = mem_rdata.
  - pc += 4, instret += 1, return to S_IDLE.
- In S_MEM without mem_rvalid: hold all state. mem_req stays low and there is no timeout.
- mem_rvalid in S_IDLE is ignored.
- Arithmetic is 32-bit modulo 2^32: pc+4 and pc+imm wrap. instret is 64-bit and wraps to 0.
- When branch and brlt are both set, branch has priority. When jal and PCx1 are both set, PCx1 has priority.

## Timing
- Reset values: pc = RESET_PC, instret = 0, state S_IDLE, in_ready = 1, mem_req = 0, mem_addr = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0, busy = 0.
- rf_wen, rf_waddr, rf_wdata, and mem_req are combinational from the accept/rvalid condition and valid in the same cycle. The register file samples them on that rising edge.
- pc, instret, and state update on the rising edge of the commit cycle.
- Latency:
  - Non-load: 1 cycle, so the next instruction can be accepted the cycle after.
  - Load: accept cycle + N wait cycles + rvalid cycle (minimum 2 cycles when rvalid arrives the cycle after mem_req).
- Reset asserted mid-load abandons the load:
  - No rf write.
  - A later mem_rvalid is ignored because state is S_IDLE.
- rst deassertion is assumed synchronised externally. Outputs hold reset values while rst is high.

## Test plan
- Reset, then add (regS 0, RegW 1, rd 5, alu_result 0x0000_0007) → rf_wen=1, waddr=5, wdata=7; pc 0x8000_0000→0x8000_0004; instret=1.
- beq with alu_zero=1, imm=0xFFFF_FFF8 at pc 0x8000_0010 → pc=0x8000_0008, rf_wen=0. Repeat with alu_zero=0 → pc=0x8000_0014.
- jal rd=1, imm=0x100 at pc 0x8000_0000 → wdata=0x8000_0004, pc=0x8000_0100. jalr with alu_result=0x8000_0203 → pc=0x8000_0202.
- Load with alu_result=0x8000_1000, rd=3, 3-cycle memory delay:
  - mem_req is a single pulse, mem_addr=0x8000_1000.
  - in_ready=0 and busy=1 for 3 cycles.
  - rvalid with rdata=0xDEAD_BEEF → waddr=3, wdata=0xDEAD_BEEF, pc+=4.
- Addi writing rd=0 → rf_wen=0, pc+=4, instret increments.
- Load in flight, assert rst, then pulse mem_rvalid → no rf_wen, pc=0x8000_0000, instret=0. Also: pc=0xFFFF_FFFC non-branch → pc wraps to 0.

Source files
------------

// File: rtl/ysyx_25060170_wbu.sv
// Write-back and next-PC unit.
// Commits non-load instructions in the cycle they are accepted.
// Holds loads in S_MEM until the data memory returns the load data.
// Owns the architectural PC and the 64-bit retired-instruction counter.
module ysyx_25060170_wbu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        jal,
    input  logic        branch,
    input  logic        brlt,
    input  logic        RegW,
    input  logic        PCx1,
    input  logic [1:0]  regS,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic [63:0] instret,
    output logic        busy
);

    typedef enum logic {S_IDLE, S_MEM} state_t;

    state_t      state_q;
    logic [31:0] pc_q, pc_d;
    logic [63:0] instret_q;
    logic [31:0] mem_addr_q;
    logic [4:0]  rd_q;
    logic        regw_q;

    logic        accept, is_load, commit_ex, start_ld, commit_ld;
    logic [31:0] pc_plus4, pc_plus_imm;

    // While rst is high nothing may be accepted or committed, so every
    // combinational output sits at its reset value.
    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q == S_MEM);
    assign accept      = in_valid && in_ready && !rst;
    assign is_load     = (regS == 2'd1);
    assign commit_ex   = accept && !is_load;
    assign start_ld    = accept && is_load;
    assign commit_ld   = (state_q == S_MEM) && mem_rvalid && !rst;
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_plus_imm = pc_q + imm;

    assign mem_req  = start_ld;
    assign mem_addr = mem_addr_q;
    assign pc       = pc_q;
    assign instret  = instret_q;

    // Next PC for a non-load commit: jalr beats jal, branch-equal beats branch-less-than.
    always_comb begin
        pc_d = pc_plus4;
        if (PCx1)                    pc_d = alu_result & ~32'h1;
        else if (jal)                pc_d = pc_plus_imm;
        else if (branch && alu_zero) pc_d = pc_plus_imm;
        else if (brlt && alu_lt)     pc_d = pc_plus_imm;
    end

    // Register-file write port: driven in the commit cycle only, zero otherwise.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (commit_ex) begin
            rf_wen   = RegW && (rd != 5'd0);
            rf_waddr = rd;
            case (regS)
                2'd2:    rf_wdata = pc_plus4;
                2'd3:    rf_wdata = pc_plus_imm;
                default: rf_wdata = alu_result;
            endcase
        end else if (commit_ld) begin
            rf_wen   = regw_q && (rd_q != 5'd0);
            rf_waddr = rd_q;
            rf_wdata = mem_rdata;
        end
    end

    // State, PC, instret and the latched load context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instret_q  <= 64'd0;
            mem_addr_q <= 32'd0;
            rd_q       <= 5'd0;
            regw_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (commit_ex) begin
                        pc_q      <= pc_d;
                        instret_q <= instret_q + 64'd1;
                    end else if (start_ld) begin
                        mem_addr_q <= alu_result;
                        rd_q       <= rd;
                        regw_q     <= RegW;
                        state_q    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (commit_ld) begin
                        pc_q      <= pc_plus4;
                        instret_q <= instret_q + 64'd1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed testbench for ysyx_25060170_wbu.
module tb_ysyx_25060170_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        jal, branch, brlt, RegW, PCx1;
    logic [1:0]  regS;
    logic [4:0]  rd;
    logic [31:0] imm, alu_result;
    logic        alu_zero, alu_lt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic [63:0] instret;
    logic        busy;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_ir = 64'd0;

    always #5 clk = ~clk;

    ysyx_25060170_wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .jal(jal), .branch(branch), .brlt(brlt), .RegW(RegW), .PCx1(PCx1),
        .regS(regS), .rd(rd), .imm(imm), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .instret(instret), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic j, input logic br, input logic bl,
                          input logic rw, input logic px, input logic [1:0] rs,
                          input logic [4:0] d, input logic [31:0] im, input logic [31:0] alu,
                          input logic z, input logic l);
        in_valid = v; jal = j; branch = br; brlt = bl; RegW = rw; PCx1 = px;
        regS = rs; rd = d; imm = im; alu_result = alu; alu_zero = z; alu_lt = l;
        #1;
    endtask

    // Clock in a committing instruction and check the resulting PC and instret.
    task automatic commit(input string tag, input logic [31:0] exp_pc);
        step();
        exp_ir = exp_ir + 64'd1;
        check({tag, ".pc"}, {32'd0, pc}, {32'd0, exp_pc});
        check({tag, ".instret"}, instret, exp_ir);
    endtask

    task automatic nop();
        set_in(1, 0, 0, 0, 1, 0, 2'd0, 5'd0, 32'd0, 32'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 0, 0);
        step();
        step();
        check("rst.pc", {32'd0, pc}, 64'h8000_0000);
        check("rst.instret", instret, 64'd0);
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.mem_req", {63'd0, mem_req}, 64'd0);
        check("rst.mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst.rf_wen", {63'd0, rf_wen}, 64'd0);
        check("rst.rf_waddr", {59'd0, rf_waddr}, 64'd0);
        check("rst.rf_wdata", {32'd0, rf_wdata}, 64'd0);
        rst = 1'b0;

        // add x5 = 7
        set_in(1, 0, 0, 0, 1, 0, 2'd0, 5'd5, 32'd0, 32'h7, 0, 0);
        check("add.wen", {63'd0, rf_wen}, 64'd1);
        check("add.waddr", {59'd0, rf_waddr}, 64'd5);
        check("add.wdata", {32'd0, rf_wdata}, 64'd7);
        commit("add", 32'h8000_0004);

        // addi to x0: no write, PC still advances
        set_in(1, 0, 0, 0, 1, 0, 2'd0, 5'd0, 32'd0, 32'h55, 0, 0);
        check("x0.wen", {63'd0, rf_wen}, 64'd0);
        commit("x0", 32'h8000_0008);
        nop(); commit("nop1", 32'h8000_000C);
        nop(); commit("nop2", 32'h8000_0010);

        // beq taken, imm -8
        set_in(1, 0, 1, 0, 0, 0, 2'd0, 5'd0, 32'hFFFF_FFF8, 32'd0, 1, 0);
        check("beq_t.wen", {63'd0, rf_wen}, 64'd0);
        commit("beq_t", 32'h8000_0008);
        // jal x0, +8 back to 0x8000_0010
        set_in(1, 1, 0, 0, 0, 0, 2'd2, 5'd0, 32'h8, 32'd0, 0, 0);
        commit("jal_back", 32'h8000_0010);
        // beq not taken
        set_in(1, 0, 1, 0, 0, 0, 2'd0, 5'd0, 32'hFFFF_FFF8, 32'h3, 0, 0);
        commit("beq_nt", 32'h8000_0014);
        // branch with zero=0 and blt with lt=1: blt takes, +0x10
        set_in(1, 0, 1, 1, 0, 0, 2'd0, 5'd0, 32'h10, 32'hFFFF_FFFF, 0, 1);
        commit("blt_t", 32'h8000_0024);
        // jal and PCx1 together: jalr target wins over pc+imm
        set_in(1, 1, 0, 0, 0, 1, 2'd2, 5'd0, 32'h44, 32'h8000_0000, 0, 0);
        commit("jalr_pri", 32'h8000_0000);

        // jal x1, +0x100
        set_in(1, 1, 0, 0, 1, 0, 2'd2, 5'd1, 32'h100, 32'd0, 0, 0);
        check("jal.waddr", {59'd0, rf_waddr}, 64'd1);
        check("jal.wdata", {32'd0, rf_wdata}, 64'h8000_0004);
        commit("jal", 32'h8000_0100);
        // jalr x1 to 0x8000_0203 -> LSB cleared
        set_in(1, 0, 0, 0, 1, 1, 2'd2, 5'd1, 32'h3, 32'h8000_0203, 0, 0);
        check("jalr.wdata", {32'd0, rf_wdata}, 64'h8000_0104);
        commit("jalr", 32'h8000_0202);
        // regS 3: x7 = pc + 0x10
        set_in(1, 0, 0, 0, 1, 0, 2'd3, 5'd7, 32'h10, 32'd0, 0, 0);
        check("auipc.wdata", {32'd0, rf_wdata}, 64'h8000_0212);
        commit("auipc", 32'h8000_0206);

        // load x3 from 0x8000_1000, three wait cycles
        set_in(1, 0, 0, 0, 1, 0, 2'd1, 5'd3, 32'd0, 32'h8000_1000, 0, 0);
        check("ld.req", {63'd0, mem_req}, 64'd1);
        check("ld.acc_wen", {63'd0, rf_wen}, 64'd0);
        step();
        set_in(1, 0, 0, 0, 1, 0, 2'd0, 5'd9, 32'd0, 32'h1234, 0, 0);
        check("ld.addr", {32'd0, mem_addr}, 64'h8000_1000);
        check("ld.pc_hold", {32'd0, pc}, 64'h8000_0206);
        for (int i = 0; i < 3; i++) begin
            check("ld.busy", {63'd0, busy}, 64'd1);
            check("ld.ready", {63'd0, in_ready}, 64'd0);
            check("ld.req_low", {63'd0, mem_req}, 64'd0);
            check("ld.wait_wen", {63'd0, rf_wen}, 64'd0);
            step();
        end
        in_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld.wen", {63'd0, rf_wen}, 64'd1);
        check("ld.waddr", {59'd0, rf_waddr}, 64'd3);
        check("ld.wdata", {32'd0, rf_wdata}, 64'hDEAD_BEEF);
        check("ld.addr_stable", {32'd0, mem_addr}, 64'h8000_1000);
        commit("ld", 32'h8000_020A);
        check("ld.busy_done", {63'd0, busy}, 64'd0);

        // rvalid while idle is ignored
        #1;
        check("idle_rv.wen", {63'd0, rf_wen}, 64'd0);
        step();
        check("idle_rv.pc", {32'd0, pc}, 64'h8000_020A);
        mem_rvalid = 1'b0;

        // PC wrap
        set_in(1, 0, 0, 0, 0, 1, 2'd0, 5'd0, 32'd0, 32'hFFFF_FFFC, 0, 0);
        commit("to_top", 32'hFFFF_FFFC);
        nop(); commit("wrap", 32'h0000_0000);

        // load abandoned by reset
        set_in(1, 0, 0, 0, 1, 0, 2'd1, 5'd4, 32'd0, 32'h8000_2000, 0, 0);
        step();
        in_valid = 1'b0;
        check("abort.busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort.pc", {32'd0, pc}, 64'h8000_0000);
        check("abort.instret", instret, 64'd0);
        check("abort.busy_clr", {63'd0, busy}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1111_2222;
        #1;
        check("abort.wen_rst", {63'd0, rf_wen}, 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort.wen_after", {63'd0, rf_wen}, 64'd0);
        step();
        mem_rvalid = 1'b0;
        check("abort.pc_after", {32'd0, pc}, 64'h8000_0000);
        check("abort.ir_after", instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
